// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter: round-robin arbiter between two requesters onto a single AXI-lite style CSR bus,
// one outstanding transaction, with a per-phase handshake timeout.
module csr_bus_arbiter #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_valid,
   input  logic [1:0]                req_write,
   input  logic [2*ADDR_WIDTH-1:0]   req_addr,
   input  logic [2*DATA_WIDTH-1:0]   req_wdata,
   output logic [1:0]                req_done,
   output logic [DATA_WIDTH-1:0]     req_rdata,
   output logic                      req_err,
   output logic [ADDR_WIDTH-1:0]     cbus_awaddr,
   output logic                      cbus_awvalid,
   input  logic                      cbus_awready,
   output logic [DATA_WIDTH-1:0]     cbus_wdata,
   output logic [DATA_WIDTH/8-1:0]   cbus_wstrb,
   output logic                      cbus_wvalid,
   input  logic                      cbus_wready,
   input  logic [1:0]                cbus_bresp,
   input  logic                      cbus_bvalid,
   output logic                      cbus_bready,
   output logic [ADDR_WIDTH-1:0]     cbus_araddr,
   output logic                      cbus_arvalid,
   input  logic                      cbus_arready,
   input  logic [DATA_WIDTH-1:0]     cbus_rdata,
   input  logic [1:0]                cbus_rresp,
   input  logic                      cbus_rvalid,
   output logic                      cbus_rready
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

   state_t                state_q, state_d;
   logic                  gnt_q, gnt_d, last_q, last_d;
   logic                  aw_q, aw_d, w_q, w_d, err_q, err_d;
   logic [1:0]            done_q, done_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  tmo, sel, aw_all, w_all;

   // on a tie the requester that did not win last time is chosen
   assign sel    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
   assign tmo    = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT));
   assign aw_all = aw_q | (cbus_awvalid & cbus_awready);
   assign w_all  = w_q | (cbus_wvalid & cbus_wready);

   assign cbus_awvalid = (state_q == WADDR) && !aw_q && !tmo;
   assign cbus_wvalid  = (state_q == WADDR) && !w_q && !tmo;
   assign cbus_bready  = (state_q == WRESP) && !tmo;
   assign cbus_arvalid = (state_q == RADDR) && !tmo;
   assign cbus_rready  = (state_q == RDATA) && !tmo;
   assign cbus_wstrb   = '1;
   assign cbus_awaddr  = addr_q;
   assign cbus_araddr  = addr_q;
   assign cbus_wdata   = wdata_q;
   assign req_done     = done_q;
   assign req_err      = err_q;
   assign req_rdata    = rdata_q;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      aw_d    = aw_all;
      w_d     = w_all;
      err_d   = err_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_d  = '0;
      cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
      case (state_q)
         IDLE: if (|req_valid) begin
            gnt_d   = sel;
            last_d  = sel;
            addr_d  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            wdata_d = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
            aw_d    = 1'b0;
            w_d     = 1'b0;
            state_d = req_write[sel] ? WADDR : RADDR;
         end
         WADDR: if (aw_all && w_all) begin
            state_d = WRESP;
            cnt_d   = '0;
         end
         WRESP: if (cbus_bvalid && cbus_bready) begin
            state_d = IDLE;
            done_d  = gnt_q ? 2'b10 : 2'b01;
            err_d   = |cbus_bresp;
         end
         RADDR: if (cbus_arvalid && cbus_arready) begin
            state_d = RDATA;
            cnt_d   = '0;
         end
         RDATA: if (cbus_rvalid && cbus_rready) begin
            state_d = IDLE;
            done_d  = gnt_q ? 2'b10 : 2'b01;
            err_d   = |cbus_rresp;
            rdata_d = cbus_rdata;
         end
         default: state_d = IDLE;
      endcase
      if (tmo) begin
         state_d = IDLE;
         done_d  = gnt_q ? 2'b10 : 2'b01;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         aw_q    <= 1'b0;
         w_q     <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         aw_q    <= aw_d;
         w_q     <= w_d;
         err_q   <= err_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_csr_bus_arbiter.sv
// tb_csr_bus_arbiter: directed and randomized transactions against a latency/arbitration model
// derived from phase durations, with a delay-programmable CSR slave.
module tb_csr_bus_arbiter;
   localparam int T = 8;

   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  req_valid, req_write, req_done;
   logic [3:0]  req_addr;
   logic [63:0] req_wdata;
   logic [31:0] req_rdata, cbus_wdata, cbus_rdata;
   logic        req_err;
   logic [1:0]  cbus_awaddr, cbus_araddr, cbus_bresp, cbus_rresp;
   logic [3:0]  cbus_wstrb;
   logic        cbus_awvalid, cbus_awready, cbus_wvalid, cbus_wready, cbus_bvalid, cbus_bready;
   logic        cbus_arvalid, cbus_arready, cbus_rvalid, cbus_rready;

   always #5 clk = ~clk;

   csr_bus_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
      .cbus_awaddr(cbus_awaddr), .cbus_awvalid(cbus_awvalid), .cbus_awready(cbus_awready),
      .cbus_wdata(cbus_wdata), .cbus_wstrb(cbus_wstrb), .cbus_wvalid(cbus_wvalid),
      .cbus_wready(cbus_wready), .cbus_bresp(cbus_bresp), .cbus_bvalid(cbus_bvalid),
      .cbus_bready(cbus_bready), .cbus_araddr(cbus_araddr), .cbus_arvalid(cbus_arvalid),
      .cbus_arready(cbus_arready), .cbus_rdata(cbus_rdata), .cbus_rresp(cbus_rresp),
      .cbus_rvalid(cbus_rvalid), .cbus_rready(cbus_rready)
   );

   // slave behaviour for the n-th served transaction: cycles of valid/ready before the slave answers
   typedef struct {
      int          aw, w, b, ar, r;
      logic [1:0]  bresp, rresp;
      logic [31:0] rdata;
   } slot_t;

   slot_t       sl[2];
   logic        wr[2];
   logic [1:0]  addr[2];
   logic [31:0] wdat[2];
   int          total = 0, bad = 0, cyc = 0, last_m;
   logic        err_m;
   logic [31:0] rdata_m;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic int hi(input int d);
      return (d < T) ? d + 1 : T;
   endfunction

   function automatic int rdly();
      return ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic slave_idle();
      {cbus_awready, cbus_wready, cbus_bvalid, cbus_arready, cbus_rvalid} = '0;
      cbus_bresp = '0;
      cbus_rresp = '0;
      cbus_rdata = '0;
   endtask

   task automatic clr();
      sl[0] = '{default: 0};
      sl[1] = '{default: 0};
   endtask

   task automatic set_req(input int i, input logic w, input logic [1:0] a, input logic [31:0] d);
      wr[i] = w;
      addr[i] = a;
      wdat[i] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      slave_idle();
      tick();
      rst = 1'b0;
      last_m = 1;
      err_m = 1'b0;
      rdata_m = '0;
      chk("reset_outputs", {cbus_awvalid, cbus_wvalid, cbus_bready, cbus_arvalid, cbus_rready, req_done,
          req_err, req_rdata, cbus_awaddr, cbus_araddr, cbus_wdata}, '0);
   endtask

   // latency = grant cycle + each reached phase lasting min(delay,T)+1 cycles, plus the done cycle
   task automatic predict(input int s, input int who, output int lat, output logic err, output logic [31:0] rd);
      int p;
      rd = rdata_m;
      if (wr[who]) begin
         p = (sl[s].aw > sl[s].w) ? sl[s].aw : sl[s].w;
         if (p >= T) begin lat = T + 2; err = 1'b1; end
         else if (sl[s].b >= T) begin lat = p + T + 3; err = 1'b1; end
         else begin lat = p + sl[s].b + 3; err = (sl[s].bresp != 0); end
      end else begin
         p = sl[s].ar;
         if (p >= T) begin lat = T + 2; err = 1'b1; end
         else if (sl[s].r >= T) begin lat = p + T + 3; err = 1'b1; end
         else begin lat = p + sl[s].r + 3; err = (sl[s].rresp != 0); rd = sl[s].rdata; end
      end
   endtask

   task automatic run(input logic [1:0] v);
      int order[2];
      int n, s, start, lat, who, guard, aw_k, w_k, b_k, ar_k, r_k;
      logic err_e;
      logic [31:0] rd_e;
      slot_t d;
      n = (v == 2'b11) ? 2 : 1;
      order[0] = (v == 2'b11) ? ((last_m == 0) ? 1 : 0) : (v[1] ? 1 : 0);
      order[1] = 1 - order[0];
      req_write = {wr[1], wr[0]};
      req_addr  = {addr[1], addr[0]};
      req_wdata = {wdat[1], wdat[0]};
      req_valid = v;
      start = cyc;
      s = 0;
      guard = 0;
      {aw_k, w_k, b_k, ar_k, r_k} = '0;
      predict(0, order[0], lat, err_e, rd_e);
      while (s < n && guard < 300) begin
         tick();
         guard++;
         if (req_done !== 2'b00 || cyc == start + lat) begin
            who = order[s];
            chk("done_vec", req_done, who ? 2'b10 : 2'b01);
            chk("done_latency", cyc - start, lat);
            chk("err", req_err, err_e);
            chk("rdata", req_rdata, rd_e);
            if (wr[who]) begin
               chk("awvalid_cycles", aw_k, hi(sl[s].aw));
               chk("wvalid_cycles", w_k, hi(sl[s].w));
            end else
               chk("arvalid_cycles", ar_k, hi(sl[s].ar));
            req_valid[who] = 1'b0;
            last_m = who;
            err_m = err_e;
            rdata_m = rd_e;
            s++;
            start = cyc;
            {aw_k, w_k, b_k, ar_k, r_k} = '0;
            if (s < n) predict(s, order[s], lat, err_e, rd_e);
         end
         if (s < n) begin d = sl[s]; who = order[s]; end
         else begin d = '{default: 0}; who = 0; end
         cbus_awready = cbus_awvalid && aw_k >= d.aw;
         if (cbus_awvalid) begin
            chk("awaddr", cbus_awaddr, addr[who]);
            aw_k++;
         end
         cbus_wready = cbus_wvalid && w_k >= d.w;
         if (cbus_wvalid) begin
            chk("wdata", cbus_wdata, wdat[who]);
            chk("wstrb", cbus_wstrb, 4'hF);
            w_k++;
         end
         cbus_bvalid = cbus_bready && b_k >= d.b;
         cbus_bresp = cbus_bvalid ? d.bresp : 2'b00;
         if (cbus_bready) b_k++;
         cbus_arready = cbus_arvalid && ar_k >= d.ar;
         if (cbus_arvalid) begin
            chk("araddr", cbus_araddr, addr[who]);
            ar_k++;
         end
         cbus_rvalid = cbus_rready && r_k >= d.r;
         cbus_rresp = cbus_rvalid ? d.rresp : 2'b00;
         cbus_rdata = cbus_rvalid ? d.rdata : $urandom;
         if (cbus_rready) r_k++;
      end
      if (s < n) begin
         chk("completions_in_budget", s, n);
         do_reset();
      end
      slave_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      slave_idle();
      do_reset();
      clr();
      set_req(0, 1'b1, 2'd1, 32'hA5);
      run(2'b01);
      do_reset();
      clr();
      set_req(0, 1'b0, 2'd2, 0);
      set_req(1, 1'b0, 2'd3, 0);
      sl[0].rdata = 32'h11;
      sl[1].rdata = 32'h22;
      run(2'b11);
      sl[0].rdata = 32'h33;
      sl[1].rdata = 32'h44;
      run(2'b11);
      clr();
      set_req(1, 1'b1, 2'd2, 32'h1234);
      sl[0].w = 2;
      run(2'b10);
      clr();
      set_req(0, 1'b0, 2'd3, 0);
      sl[0].rresp = 2'b10;
      sl[0].rdata = 32'h5A;
      run(2'b01);
      clr();
      set_req(1, 1'b1, 2'd0, 32'hBEEF);
      run(2'b10);
      chk("rdata_kept_after_write", req_rdata, 32'h5A);
      clr();
      set_req(0, 1'b0, 2'd1, 0);
      sl[0].ar = 20;
      run(2'b01);
      // abort a write while it waits for its response
      set_req(0, 1'b1, 2'd2, 32'hCAFE);
      req_write = 2'b01;
      req_addr = {2'd0, 2'd2};
      req_wdata = {32'd0, 32'hCAFE};
      req_valid = 2'b01;
      cbus_awready = 1'b1;
      cbus_wready = 1'b1;
      k = 0;
      while (cbus_bready !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      chk("reached_wresp", cbus_bready, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_done_after_abort", req_done, 2'b00);
      end
      clr();
      set_req(1, 1'b0, 2'd2, 0);
      sl[0].rdata = 32'h77;
      run(2'b10);
      for (int i = 0; i < 40; i++) begin
         for (int j = 0; j < 2; j++) begin
            set_req(j, 1'($urandom_range(0, 1)), 2'($urandom), $urandom);
            sl[j].aw = rdly();
            sl[j].w = rdly();
            sl[j].b = rdly();
            sl[j].ar = rdly();
            sl[j].r = rdly();
            sl[j].bresp = 2'($urandom);
            sl[j].rresp = 2'($urandom);
            sl[j].rdata = $urandom;
         end
         run(2'($urandom_range(1, 3)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/csr_bus_arbiter.md
CSR_BUS_ARBITER -- requirements
Module: csr_bus_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 2, meaning the CSR word-address width.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 32, meaning the CSR data width.
REQ-003 The block SHALL expose parameter TIMEOUT, default 255, meaning the maximum number of cycles waited for any bus handshake.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high. Clock and reset ports are listed first below.
REQ-005 The block SHALL provide these ports, one per line: name, direction, width, meaning.
  clk           input   1               clock
  rst           input   1               synchronous active-high reset
  req_valid     input   2               per-requester transaction request
  req_write     input   2               per-requester 1=write, 0=read
  req_addr      input   2*ADDR_WIDTH    per-requester address (requester i at slice i)
  req_wdata     input   2*DATA_WIDTH    per-requester write data
  req_done      output  2               one-cycle completion pulse, per requester
  req_rdata     output  DATA_WIDTH      read data of the last completed read
  req_err       output  1               error flag of the last completed transaction
  cbus_awaddr   output  ADDR_WIDTH      write address
  cbus_awvalid  output  1               write address valid
  cbus_awready  input   1               write address ready
  cbus_wdata    output  DATA_WIDTH      write data
  cbus_wstrb    output  DATA_WIDTH/8    write strobes
  cbus_wvalid   output  1               write data valid
  cbus_wready   input   1               write data ready
  cbus_bresp    input   2               write response
  cbus_bvalid   input   1               write response valid
  cbus_bready   output  1               write response ready
  cbus_araddr   output  ADDR_WIDTH      read address
  cbus_arvalid  output  1               read address valid
  cbus_arready  input   1               read address ready
  cbus_rdata    input   DATA_WIDTH      read data
  cbus_rresp    input   2               read response
  cbus_rvalid   input   1               read data valid
  cbus_rready   output  1               read data ready

Function
REQ-006 The FSM SHALL have five states: IDLE, WADDR (AW and W phases), WRESP, RADDR and RDATA. Only one transaction SHALL be outstanding at a time.
REQ-007 In IDLE with exactly one req_valid bit set, that requester SHALL be granted. With both bits set, the requester not granted last SHALL win (round-robin). After reset, requester 0 SHALL win the first tie.
REQ-008 At grant the block SHALL latch the requester index, write flag, address and wdata. The state SHALL then become WADDR (write) or RADDR (read). Requester inputs SHALL be ignored until that requester's req_done.
REQ-009 In WADDR, cbus_awvalid and cbus_wvalid SHALL both rise in the first WADDR cycle.
  - Each SHALL drop independently the cycle after its own valid&ready handshake.
  - The state SHALL advance to WRESP once both handshakes have occurred, including both in the same cycle.
REQ-010 cbus_wstrb SHALL be all ones whenever cbus_wvalid=1. Address and data outputs SHALL stay stable while the corresponding valid is high.
REQ-011 In WRESP, cbus_bready SHALL be 1. On bvalid&bready the block SHALL:
  - pulse req_done[grant] in the next cycle;
  - set req_err=(bresp!=0);
  - return to IDLE.
REQ-012 In RADDR, cbus_arvalid SHALL be 1 until the arvalid&arready handshake, then the state SHALL become RDATA.
REQ-013 In RDATA, cbus_rready SHALL be 1. On rvalid&rready the block SHALL:
  - capture cbus_rdata into req_rdata;
  - set req_err=(rresp!=0);
  - pulse req_done[grant] in the next cycle;
  - return to IDLE.
REQ-014 req_rdata and req_err SHALL hold their value until the next completion. A write completion SHALL NOT alter req_rdata.
REQ-015 The block SHALL spend at least one cycle in IDLE between transactions. With a zero-wait slave, latency from req_valid sampled in IDLE to req_done SHALL be 3 cycles for writes and 3 cycles for reads.
REQ-016 A cycle counter SHALL clear on entry to every non-IDLE state and increment each cycle spent in that state. When it reaches TIMEOUT, the block SHALL:
  - deassert all bus valids and readies;
  - pulse req_done[grant] with req_err=1;
  - leave req_rdata unchanged;
  - return to IDLE.
REQ-017 bready and rready SHALL be 0 outside WRESP and RDATA. Responses arriving in other states SHALL be ignored.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL:
  - force all cbus valid and ready outputs to 0;
  - force req_done=0, req_err=0 and req_rdata=0;
  - set cbus_awaddr, cbus_araddr and cbus_wdata to 0;
  - set the state to IDLE and the round-robin pointer to favour requester 0.
REQ-019 Reset asserted mid-transaction SHALL abort it immediately with no req_done pulse.

Verification
REQ-020 Zero-wait slave, req 0 writes addr 1, data 0xA5 -> awvalid and wvalid high 1 cycle, bready taken, req_done=2'b01 3 cycles after request, req_err=0.
REQ-021 Both requesters issue reads in the same cycle after reset -> req 0 served first, then req 1. Then both request again -> req 0 is granted again, because req 1 won the previous grant.
REQ-022 Slave asserts awready 2 cycles before wready -> awvalid drops after its handshake, wvalid holds, WRESP is entered only after wready; one req_done.
REQ-023 Read with rresp=2'b10 and rdata=0x5A -> req_rdata=0x5A, req_err=1. A following write with bresp=0 -> req_err=0, req_rdata still 0x5A.
REQ-024 Slave never asserts arready, TIMEOUT=8 -> arvalid drops after 8 cycles, req_done with req_err=1.
REQ-025 rst pulsed while in WRESP -> all outputs at reset values the next cycle, no req_done. A new request after reset completes normally.
